// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the CPU-to-word-memory access controller:
// access size codes, controller state encoding and default memory depth.
package mem_access_ctrl_pkg;

   localparam int MEM_WORDS = 50;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD     = 3'd1,
      WR     = 3'd2,
      RMW_RD = 3'd3,
      RMW_WR = 3'd4,
      RESP   = 3'd5
   } state_t;

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Big-endian byte-lane handling: extracts and extends sub-word load data
// from a memory word, and merges right-aligned store data into that word.
module mem_lane_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        signed_ld,
   input  logic [1:0]  byte_off,
   input  logic [31:0] word_in,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Offset 0 is the most significant lane.
   always_comb begin
      byte_sel = word_in[31:24];
      case (byte_off)
         2'd0:    byte_sel = word_in[31:24];
         2'd1:    byte_sel = word_in[23:16];
         2'd2:    byte_sel = word_in[15:8];
         default: byte_sel = word_in[7:0];
      endcase
   end

   assign half_sel = byte_off[1] ? word_in[15:0] : word_in[31:16];

   always_comb begin
      load_data = word_in;
      merged    = word_in;
      case (size)
         SZ_BYTE: begin
            load_data = {{24{signed_ld & byte_sel[7]}}, byte_sel};
            case (byte_off)
               2'd0:    merged[31:24] = wdata[7:0];
               2'd1:    merged[23:16] = wdata[7:0];
               2'd2:    merged[15:8]  = wdata[7:0];
               default: merged[7:0]   = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            load_data = {{16{signed_ld & half_sel[15]}}, half_sel};
            if (byte_off[1]) merged[15:0]  = wdata[15:0];
            else             merged[31:16] = wdata[15:0];
         end
         default: begin
            load_data = word_in;
            merged    = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-request controller between a CPU load/store port and a word-wide
// memory; sub-word stores are done as read-modify-write of the full word.
module mem_access_ctrl #(
   parameter int MEM_WORDS = mem_access_ctrl_pkg::MEM_WORDS,
   parameter int WAW       = 6
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic           req_we,
   input  logic [1:0]     req_size,
   input  logic           req_signed,
   input  logic [WAW+1:0] req_addr,
   input  logic [31:0]    req_wdata,
   output logic           rsp_valid,
   output logic [31:0]    rsp_rdata,
   output logic           rsp_err,
   output logic [WAW-1:0] address,
   output logic [31:0]    writeData,
   output logic           memwrite,
   output logic           memread,
   input  logic [31:0]    out32
);

   import mem_access_ctrl_pkg::*;

   state_t         state, next_state;
   logic [WAW-1:0] word_addr_q;
   logic [1:0]     off_q;
   logic [1:0]     size_q;
   logic           signed_q;
   logic           we_q;
   logic           err_q;
   logic [31:0]    wdata_q;
   logic [31:0]    word_q;
   logic           accept;
   logic           req_err;
   logic [31:0]    load_data;
   logic [31:0]    merged;

   assign req_ready = (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign address   = word_addr_q;

   // A bad request is flagged at acceptance and never touches memory.
   always_comb begin
      req_err = 1'b0;
      case (req_size)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = |req_addr[1:0];
         default: req_err = 1'b1;
      endcase
      if (32'(req_addr[WAW+1:2]) >= 32'(MEM_WORDS)) req_err = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         word_addr_q <= '0;
         off_q       <= '0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         we_q        <= 1'b0;
         err_q       <= 1'b0;
         wdata_q     <= '0;
         word_q      <= '0;
      end else begin
         if (accept) begin
            word_addr_q <= req_addr[WAW+1:2];
            off_q       <= req_addr[1:0];
            size_q      <= req_size;
            signed_q    <= req_signed;
            we_q        <= req_we;
            err_q       <= req_err;
            wdata_q     <= req_wdata;
         end
         if (memread) word_q <= out32;
      end
   end

   // Strobes are decoded from state alone so a reset drops them at once.
   always_comb begin
      next_state = state;
      memread    = 1'b0;
      memwrite   = 1'b0;
      writeData  = '0;
      rsp_valid  = 1'b0;
      rsp_err    = 1'b0;
      rsp_rdata  = '0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               if (req_err)                next_state = RESP;
               else if (!req_we)           next_state = RD;
               else if (req_size == SZ_WORD) next_state = WR;
               else                        next_state = RMW_RD;
            end
         end
         RD: begin
            memread    = 1'b1;
            next_state = RESP;
         end
         WR: begin
            memwrite   = 1'b1;
            writeData  = wdata_q;
            next_state = RESP;
         end
         RMW_RD: begin
            memread    = 1'b1;
            next_state = RMW_WR;
         end
         RMW_WR: begin
            memwrite   = 1'b1;
            writeData  = merged;
            next_state = RESP;
         end
         RESP: begin
            rsp_valid  = 1'b1;
            rsp_err    = err_q;
            if (!we_q && !err_q) rsp_rdata = load_data;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   mem_lane_align u_lane (
      .size      (size_q),
      .signed_ld (signed_q),
      .byte_off  (off_q),
      .word_in   (word_q),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random loads/stores
// checked against a byte-level reference model of the memory.
module tb_mem_access_ctrl;

   localparam int WAW   = 6;
   localparam int WORDS = 50;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           req_valid;
   logic           req_ready;
   logic           req_we;
   logic [1:0]     req_size;
   logic           req_signed;
   logic [WAW+1:0] req_addr;
   logic [31:0]    req_wdata;
   logic           rsp_valid;
   logic [31:0]    rsp_rdata;
   logic           rsp_err;
   logic [WAW-1:0] address;
   logic [31:0]    writeData;
   logic           memwrite;
   logic           memread;
   logic [31:0]    out32;

   logic [31:0] mem     [0:63];
   logic [31:0] ref_mem [0:63];
   logic        mem_init_done = 1'b0;

   int checks   = 0;
   int failures = 0;

   mem_access_ctrl #(.MEM_WORDS(WORDS), .WAW(WAW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .address    (address),
      .writeData  (writeData),
      .memwrite   (memwrite),
      .memread    (memread),
      .out32      (out32)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] initWord(input int i);
      if (i == 0) return 32'h00A11822;
      return (32'h9E3779B9 * 32'(i)) ^ 32'h5A5A0F0F;
   endfunction

   // Attached memory: combinational read, write on posedge.
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
         mem_init_done <= 1'b1;
      end else if (memwrite) begin
         mem[address] <= writeData;
      end
   end

   assign out32 = mem[address];

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) checkOutput("rd_wr_exclusive", 32'(memread & memwrite), 32'd0);
   end

   // Reference behaviour: byte-addressed big-endian memory with word storage.
   function automatic void refModel(input logic we, input logic [1:0] size, input logic sgn,
                                    input logic [7:0] addr, input logic [31:0] wdata,
                                    output logic [31:0] rdata, output logic err,
                                    output int lat, output int rd_cyc, output int wr_cyc);
      int nbytes, off, w, shift;
      logic [31:0] mask, v;
      off    = int'(addr) % 4;
      w      = int'(addr) / 4;
      nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      err    = (size == 2'd3) || (off % nbytes != 0) || (w >= WORDS);
      rdata  = 32'd0;
      if (err) begin
         lat = 1; rd_cyc = 0; wr_cyc = 0;
         return;
      end
      shift = 8 * (4 - nbytes - off);
      mask  = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
      if (!we) begin
         v = (ref_mem[w] >> shift) & mask;
         if (sgn && nbytes < 4 && v[8 * nbytes - 1]) v = v | ~mask;
         rdata = v;
         lat = 2; rd_cyc = 1; wr_cyc = 0;
      end else begin
         ref_mem[w] = (ref_mem[w] & ~(mask << shift)) | ((wdata & mask) << shift);
         lat    = (nbytes == 4) ? 2 : 3;
         rd_cyc = (nbytes == 4) ? 0 : 1;
         wr_cyc = 1;
      end
   endfunction

   task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sgn,
                                input logic [7:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err,
                                output int lat, output int rd_cyc, output int wr_cyc);
      int waitn = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      while (!req_ready && waitn < 20) begin
         @(negedge clk);
         waitn++;
      end
      checkOutput("accept_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; rd_cyc = 0; wr_cyc = 0; rdata = 32'd0; err = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         rd_cyc += int'(memread);
         wr_cyc += int'(memwrite);
      end while (!rsp_valid && lat < 20);
      if (rsp_valid) begin
         rdata = rsp_rdata;
         err   = rsp_err;
      end else begin
         lat = -1;
      end
      @(negedge clk);
      checkOutput("rsp_one_cycle", 32'(rsp_valid), 32'd0);
   endtask

   task automatic doReq(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                        input logic [7:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
      logic [31:0] exp_rdata;
      logic        exp_err, err;
      int          exp_lat, exp_rd, exp_wr, lat, rd_cyc, wr_cyc;
      refModel(we, size, sgn, addr, wdata, exp_rdata, exp_err, exp_lat, exp_rd, exp_wr);
      applyStimulus(we, size, sgn, addr, wdata, rdata, err, lat, rd_cyc, wr_cyc);
      checkOutput({tag, "_rdata"}, rdata, exp_rdata);
      checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
      checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({tag, "_memread_cycles"}, 32'(rd_cyc), 32'(exp_rd));
      checkOutput({tag, "_memwrite_cycles"}, 32'(wr_cyc), 32'(exp_wr));
   endtask

   initial begin
      logic [31:0] rd;
      int issued, got, cyc, sawrsp, r;
      int acc_cyc[4];
      logic accepting;

      for (int i = 0; i < 64; i++) ref_mem[i] = initWord(i);
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;

      #12;
      checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_err", 32'(rsp_err), 32'd0);
      checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
      checkOutput("reset_memread", 32'(memread), 32'd0);
      checkOutput("reset_memwrite", 32'(memwrite), 32'd0);
      checkOutput("reset_address", 32'(address), 32'd0);
      checkOutput("reset_writeData", writeData, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      doReq("ld_byte_a1", 1'b0, 2'b00, 1'b0, 8'h01, 32'h0, rd);
      checkOutput("ld_byte_a1_const", rd, 32'h000000A1);
      doReq("ld_half_a2_s", 1'b0, 2'b01, 1'b1, 8'h02, 32'h0, rd);
      checkOutput("ld_half_a2_const", rd, 32'h00001822);
      doReq("ld_word_a0", 1'b0, 2'b10, 1'b0, 8'h00, 32'h0, rd);
      checkOutput("ld_word_a0_const", rd, 32'h00A11822);
      doReq("st_byte_a2", 1'b1, 2'b00, 1'b0, 8'h02, 32'h000000FF, rd);
      doReq("ld_byte_a2_s", 1'b0, 2'b00, 1'b1, 8'h02, 32'h0, rd);
      checkOutput("ld_byte_a2_const", rd, 32'hFFFFFFFF);
      doReq("ld_word_merged", 1'b0, 2'b10, 1'b0, 8'h00, 32'h0, rd);
      checkOutput("ld_word_merged_const", rd, 32'h00A1FF22);
      doReq("ld_word_misaligned", 1'b0, 2'b10, 1'b0, 8'h02, 32'h0, rd);
      doReq("st_word_range", 1'b1, 2'b10, 1'b0, 8'hC8, 32'hDEADBEEF, rd);
      doReq("ld_size_illegal", 1'b0, 2'b11, 1'b0, 8'h04, 32'h0, rd);

      // Reset during a word store must suppress the write and the response.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
      req_addr = 8'h04; req_wdata = 32'h12345678;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_wr_active", 32'(memwrite), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_wr_dropped", 32'(memwrite), 32'd0);
      checkOutput("rst_address", 32'(address), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      sawrsp = 0;
      repeat (5) begin
         @(negedge clk);
         sawrsp += int'(rsp_valid);
      end
      checkOutput("rst_no_rsp", 32'(sawrsp), 32'd0);
      checkOutput("rst_word1_kept", mem[1], ref_mem[1]);
      checkOutput("rst_idle_ready", 32'(req_ready), 32'd1);

      // Back-to-back word loads with req_valid held high.
      issued = 0; got = 0; cyc = 0;
      for (int i = 0; i < 4; i++) acc_cyc[i] = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0; req_addr = 8'h00;
      while (got < 4 && cyc < 60) begin
         if (rsp_valid) begin
            checkOutput($sformatf("b2b_rdata%0d", got), rsp_rdata, ref_mem[got]);
            checkOutput($sformatf("b2b_err%0d", got), 32'(rsp_err), 32'd0);
            got++;
         end
         accepting = req_ready && req_valid;
         if (accepting) begin
            acc_cyc[issued] = cyc;
            issued++;
         end
         @(posedge clk);
         #1;
         if (accepting) begin
            if (issued < 4) req_addr = 8'(issued * 4);
            else            req_valid = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      req_valid = 1'b0;
      checkOutput("b2b_count", 32'(got), 32'd4);
      for (int i = 1; i < 4; i++)
         checkOutput($sformatf("b2b_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

      for (int i = 0; i < 60; i++) begin
         logic [1:0] sz;
         r  = int'($urandom_range(0, 9));
         sz = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
         doReq($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 207)), $urandom, rd);
      end

      for (int i = 0; i < WORDS; i++)
         checkOutput($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
